// File: rtl/bomber_status_scheduler_if.sv
// Status-update write channel between the game-logic / register side and the
// player status scheduler.
//   i_wr_valid : update request
//   o_wr_ready : scheduler can accept an update
//   i_wr_id    : player select (0/1)
//   i_wr_data  : [4:0] pos_x, [9:5] pos_y, [12:10] lives, [15:13] bombs
// master = update source, slave = scheduler.
interface bomber_status_scheduler_if;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic        i_wr_id;
    logic [15:0] i_wr_data;

    modport master (
        output i_wr_valid,
        output i_wr_id,
        output i_wr_data,
        input  o_wr_ready
    );

    modport slave (
        input  i_wr_valid,
        input  i_wr_id,
        input  i_wr_data,
        output o_wr_ready
    );
endinterface

// File: rtl/bomber_status_scheduler.sv
// Per-player status word scheduler for the two player text overlays.
// Accepts binary updates over a valid/ready channel, clamps the fields,
// converts X/Y positions to tens/units digits in a short sequential FSM, and
// packs the result into a per-player shadow register. Shadows holding new
// data are committed to the overlay-facing outputs on the rising edge of
// vertical blank only, so displayed text never changes mid-frame.
// Ports:
//   i_pclk        : pixel clock (only clock)
//   i_rst         : synchronous active-high reset
//   i_vblnk       : vertical blank; rising edge commits pending shadows
//   wr            : update channel (slave side)
//   o_axi_data_0/1: committed status word per player
//                   [0] x tens, [4:1] x units, [5] y tens, [9:6] y units,
//                   [11:10] lives, [13:12] bombs
//   o_pending     : bit n set = shadow n not yet committed
//   o_commit      : one-cycle pulse in the cycle after a commit
module bomber_status_scheduler #(
    parameter int unsigned POS_W     = 5,
    parameter int unsigned POS_MAX   = 19,
    parameter int unsigned LIVES_MAX = 3,
    parameter int unsigned BOMBS_MAX = 3
) (
    input  logic                           i_pclk,
    input  logic                           i_rst,
    input  logic                           i_vblnk,
    bomber_status_scheduler_if.slave       wr,
    output logic [13:0]                    o_axi_data_0,
    output logic [13:0]                    o_axi_data_1,
    output logic [1:0]                     o_pending,
    output logic                           o_commit
);

    typedef enum logic [2:0] {
        IDLE,
        CLAMP,
        CONV_X,
        CONV_Y,
        PACK
    } state_t;

    state_t state, state_next;

    logic             id_q;
    logic [POS_W-1:0] x_raw, y_raw;
    logic [2:0]       lives_raw, bombs_raw;
    logic [POS_W-1:0] x_c, y_c;
    logic [1:0]       lives_c, bombs_c;
    logic             x_tens, y_tens;
    logic [3:0]       x_units, y_units;
    logic [13:0]      shadow_0, shadow_1;
    logic [13:0]      pack_word;
    logic             vblnk_q;
    logic             vb_rise;

    assign wr.o_wr_ready = (state == IDLE);
    assign vb_rise       = i_vblnk & ~vblnk_q;
    assign pack_word     = {bombs_c, lives_c, y_units, y_tens, x_units, x_tens};

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr.i_wr_valid) state_next = CLAMP;
            CLAMP:   state_next = CONV_X;
            CONV_X:  state_next = CONV_Y;
            CONV_Y:  state_next = PACK;
            PACK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            id_q         <= 1'b0;
            x_raw        <= '0;
            y_raw        <= '0;
            lives_raw    <= '0;
            bombs_raw    <= '0;
            x_c          <= '0;
            y_c          <= '0;
            lives_c      <= '0;
            bombs_c      <= '0;
            x_tens       <= 1'b0;
            x_units      <= '0;
            y_tens       <= 1'b0;
            y_units      <= '0;
            shadow_0     <= '0;
            shadow_1     <= '0;
            o_axi_data_0 <= '0;
            o_axi_data_1 <= '0;
            o_pending    <= '0;
            o_commit     <= 1'b0;
            vblnk_q      <= 1'b0;
        end else begin
            vblnk_q  <= i_vblnk;
            o_commit <= vb_rise & (|o_pending);

            // Commit reads the shadows before any PACK write at this edge.
            // A PACK landing on the same edge re-sets its pending bit below,
            // overriding the clear so the new word goes out next frame.
            if (vb_rise) begin
                if (o_pending[0]) o_axi_data_0 <= shadow_0;
                if (o_pending[1]) o_axi_data_1 <= shadow_1;
                o_pending <= '0;
            end

            case (state)
                IDLE: begin
                    if (wr.i_wr_valid) begin
                        id_q      <= wr.i_wr_id;
                        x_raw     <= wr.i_wr_data[POS_W-1:0];
                        y_raw     <= wr.i_wr_data[2*POS_W-1:POS_W];
                        lives_raw <= wr.i_wr_data[12:10];
                        bombs_raw <= wr.i_wr_data[15:13];
                    end
                end
                CLAMP: begin
                    x_c     <= (x_raw > POS_W'(POS_MAX)) ? POS_W'(POS_MAX) : x_raw;
                    y_c     <= (y_raw > POS_W'(POS_MAX)) ? POS_W'(POS_MAX) : y_raw;
                    lives_c <= (lives_raw > 3'(LIVES_MAX)) ? 2'(LIVES_MAX) : lives_raw[1:0];
                    bombs_c <= (bombs_raw > 3'(BOMBS_MAX)) ? 2'(BOMBS_MAX) : bombs_raw[1:0];
                end
                CONV_X: begin
                    if (x_c >= POS_W'(10)) begin
                        x_tens  <= 1'b1;
                        x_units <= 4'(x_c - POS_W'(10));
                    end else begin
                        x_tens  <= 1'b0;
                        x_units <= 4'(x_c);
                    end
                end
                CONV_Y: begin
                    if (y_c >= POS_W'(10)) begin
                        y_tens  <= 1'b1;
                        y_units <= 4'(y_c - POS_W'(10));
                    end else begin
                        y_tens  <= 1'b0;
                        y_units <= 4'(y_c);
                    end
                end
                PACK: begin
                    if (id_q) shadow_1 <= pack_word;
                    else      shadow_0 <= pack_word;
                    o_pending[id_q] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bomber_status_scheduler.sv
// Directed self-checking bench for bomber_status_scheduler.
module tb_bomber_status_scheduler;

    logic        i_pclk = 1'b0;
    logic        i_rst;
    logic        i_vblnk;
    logic [13:0] o_axi_data_0;
    logic [13:0] o_axi_data_1;
    logic [1:0]  o_pending;
    logic        o_commit;

    int checks = 0;
    int errors = 0;

    bomber_status_scheduler_if wr_if ();

    bomber_status_scheduler #(
        .POS_W     (5),
        .POS_MAX   (19),
        .LIVES_MAX (3),
        .BOMBS_MAX (3)
    ) dut (
        .i_pclk       (i_pclk),
        .i_rst        (i_rst),
        .i_vblnk      (i_vblnk),
        .wr           (wr_if.slave),
        .o_axi_data_0 (o_axi_data_0),
        .o_axi_data_1 (o_axi_data_1),
        .o_pending    (o_pending),
        .o_commit     (o_commit)
    );

    always #5 i_pclk = ~i_pclk;

    task automatic tick();
        @(posedge i_pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Single transfer: valid is high across exactly one edge while IDLE.
    task automatic send(input logic id, input logic [15:0] data);
        wr_if.i_wr_valid = 1'b1;
        wr_if.i_wr_id    = id;
        wr_if.i_wr_data  = data;
        tick();
        wr_if.i_wr_valid = 1'b0;
        wr_if.i_wr_data  = 16'hFFFF;
    endtask

    task automatic vblank_on();
        i_vblnk = 1'b1;
        tick();
    endtask

    task automatic vblank_off();
        i_vblnk = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int pulses;
        int n;

        i_rst            = 1'b1;
        i_vblnk          = 1'b0;
        wr_if.i_wr_valid = 1'b0;
        wr_if.i_wr_id    = 1'b0;
        wr_if.i_wr_data  = '0;
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state
        chk("rst_axi0",    16'(o_axi_data_0), 16'h0000);
        chk("rst_axi1",    16'(o_axi_data_1), 16'h0000);
        chk("rst_pending", 16'(o_pending),    16'h0000);
        chk("rst_ready",   16'(wr_if.o_wr_ready), 16'h0001);
        chk("rst_commit",  16'(o_commit),     16'h0000);

        // Idle 100 cycles with vblank toggling: nothing pending, no commit
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            i_vblnk = (i % 20) >= 10;
            tick();
            if (o_commit) pulses++;
        end
        i_vblnk = 1'b0;
        tick();
        chk("idle_commit_pulses", 16'(pulses), 16'h0000);
        chk("idle_axi0",    16'(o_axi_data_0), 16'h0000);
        chk("idle_axi1",    16'(o_axi_data_1), 16'h0000);
        chk("idle_ready",   16'(wr_if.o_wr_ready), 16'h0001);

        // id0: x13 y7 lives2 bombs1 -> 0x19C7
        send(1'b0, 16'h28ED);
        for (int i = 0; i < 4; i++) chk("w0_ready_low", 16'(wr_if.o_wr_ready), 16'h0000);
        // the four low samples are taken after each edge below
        tick(); chk("w0_ready_low1", 16'(wr_if.o_wr_ready), 16'h0000);
        tick(); chk("w0_ready_low2", 16'(wr_if.o_wr_ready), 16'h0000);
        tick(); chk("w0_ready_low3", 16'(wr_if.o_wr_ready), 16'h0000);
        tick(); chk("w0_ready_back", 16'(wr_if.o_wr_ready), 16'h0001);
        chk("w0_pending",   16'(o_pending),    16'h0001);
        chk("w0_axi0_hold", 16'(o_axi_data_0), 16'h0000);
        vblank_on();
        chk("w0_axi0",      16'(o_axi_data_0), 16'h19C7);
        chk("w0_axi1",      16'(o_axi_data_1), 16'h0000);
        chk("w0_commit",    16'(o_commit),     16'h0001);
        chk("w0_pend_clr",  16'(o_pending),    16'h0000);
        tick();
        chk("w0_commit_one", 16'(o_commit),    16'h0000);
        vblank_off();

        // id1 with clamping: x25 y31 lives7 bombs5 -> 0x3E73
        send(1'b1, 16'hBFF9);
        tick(); tick(); tick(); tick();
        chk("w1_pending",   16'(o_pending),    16'h0002);
        vblank_on();
        chk("w1_axi1",      16'(o_axi_data_1), 16'h3E73);
        chk("w1_axi0_hold", 16'(o_axi_data_0), 16'h19C7);
        chk("w1_commit",    16'(o_commit),     16'h0001);
        vblank_off();

        // id0 x10 y10 lives0 bombs0 with PACK on the vblank rise edge
        send(1'b0, 16'h014A);
        tick(); tick(); tick();       // now in PACK
        vblank_on();                  // PACK edge == vblank rise edge
        chk("co_axi0_hold", 16'(o_axi_data_0), 16'h19C7);
        chk("co_commit",    16'(o_commit),     16'h0000);
        chk("co_pending",   16'(o_pending),    16'h0001);
        chk("co_ready",     16'(wr_if.o_wr_ready), 16'h0001);
        vblank_off();
        chk("co_axi0_still", 16'(o_axi_data_0), 16'h19C7);
        vblank_on();
        chk("co_axi0_next", 16'(o_axi_data_0), 16'h0021);
        chk("co_commit2",   16'(o_commit),     16'h0001);
        chk("co_pend_clr",  16'(o_pending),    16'h0000);
        vblank_off();

        // valid held high: A (x3 y4 l1 b2) then B (x18 y0 l3 b0 -> 0x0C11)
        wr_if.i_wr_valid = 1'b1;
        wr_if.i_wr_id    = 1'b0;
        wr_if.i_wr_data  = 16'h4483;
        tick();                        // transfer A
        wr_if.i_wr_data  = 16'h0C12;
        n = 0;
        while (n < 10 && wr_if.o_wr_ready !== 1'b1) begin
            tick();
            n++;
        end
        chk("b2b_gap_cycles", 16'(n + 1), 16'h0005);
        tick();                        // transfer B
        wr_if.i_wr_valid = 1'b0;
        chk("b2b_second_taken", 16'(wr_if.o_wr_ready), 16'h0000);
        tick(); tick(); tick(); tick();
        chk("b2b_pending",  16'(o_pending),    16'h0001);
        vblank_on();
        chk("b2b_axi0_last", 16'(o_axi_data_0), 16'h0C11);
        vblank_off();

        // reset in CONV_X aborts the update
        send(1'b1, 16'h2441);          // x1 y2 l1 b1
        tick();                        // now in CONV_X
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rc_ready",    16'(wr_if.o_wr_ready), 16'h0001);
        chk("rc_pending",  16'(o_pending),    16'h0000);
        chk("rc_axi0",     16'(o_axi_data_0), 16'h0000);
        chk("rc_axi1",     16'(o_axi_data_1), 16'h0000);
        tick(); tick(); tick(); tick(); tick();
        chk("rc_no_pack",  16'(o_pending),    16'h0000);
        vblank_on();
        chk("rc_commit",   16'(o_commit),     16'h0000);
        chk("rc_axi1_vb",  16'(o_axi_data_1), 16'h0000);
        vblank_off();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
